// File: rtl/cq_dispatch_port.sv
// cq_dispatch_port: per-core task dequeue/start/finish/abort responder with a small ready buffer
module cq_dispatch_port #(
   parameter int DEPTH   = 4,
   parameter int CORE_ID = 0,
   parameter int TASK_W  = 32,
   parameter int TTYPE_W = 4,
   parameter int SLOT_W  = 8,
   parameter int CHILD_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy_valid,
   output logic               rdy_ready,
   input  logic [TASK_W-1:0]  rdy_task,
   input  logic [SLOT_W-1:0]  rdy_slot,
   input  logic               task_arvalid,
   input  logic [TTYPE_W-1:0] task_araddr,
   output logic               task_rvalid,
   output logic [TASK_W-1:0]  task_rdata,
   output logic [SLOT_W-1:0]  task_rslot,
   input  logic               start_task_valid,
   input  logic [SLOT_W-1:0]  start_task_slot,
   output logic               start_task_ready,
   input  logic               finish_task_valid,
   input  logic [SLOT_W-1:0]  finish_task_slot,
   input  logic [CHILD_W-1:0] finish_task_num_children,
   input  logic               finish_task_undo_log_write,
   output logic               finish_task_ready,
   output logic               abort_running_task,
   output logic [SLOT_W-1:0]  abort_running_slot,
   input  logic               abort_req_valid,
   input  logic [SLOT_W-1:0]  abort_req_slot,
   output logic               started_valid,
   output logic [SLOT_W-1:0]  started_slot,
   output logic               finished_valid,
   input  logic               finished_ready,
   output logic [SLOT_W-1:0]  finished_slot,
   output logic [CHILD_W-1:0] finished_children,
   output logic               finished_undo,
   output logic               finished_aborted,
   output logic               dropped_valid,
   output logic [SLOT_W-1:0]  dropped_slot,
   output logic [31:0]        num_dispatched
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   typedef enum logic [1:0] {IDLE, DISPATCHED, RUNNING, FINISHING} state_t;
   state_t             state;
   logic [TASK_W-1:0]  task_q [DEPTH];
   logic [SLOT_W-1:0]  slot_q [DEPTH];
   logic [DEPTH-1:0]   live_q, live_nxt, drop_mask;
   logic [PW-1:0]      wr_ptr, rd_ptr, count;
   logic [AW-1:0]      rd_idx, wr_idx;
   logic [SLOT_W-1:0]  run_slot;
   logic               abort_flag, push, pop, idle_head, active;
   logic               fin_hs, start_hs, run_hit, disp_hit, abort_run, drop_en;
   // head-of-buffer dequeue response, handshakes and abort routing decisions
   always_comb begin
      count = wr_ptr - rd_ptr;
      rd_idx = rd_ptr[AW-1:0];
      wr_idx = wr_ptr[AW-1:0];
      rdy_ready = count < PW'(DEPTH);
      push = rdy_valid & rdy_ready;
      task_rdata = task_q[rd_idx];
      task_rslot = slot_q[rd_idx];
      idle_head = (state == IDLE) & (count != '0);
      task_rvalid = idle_head & task_arvalid & live_q[rd_idx] & (task_rdata[TTYPE_W-1:0] == task_araddr);
      pop = task_rvalid | (idle_head & !live_q[rd_idx]);
      active = (state == DISPATCHED) | (state == RUNNING);
      start_task_ready = state == DISPATCHED;
      finish_task_ready = active & !finished_valid;
      fin_hs = finish_task_ready & finish_task_valid & (finish_task_slot == run_slot);
      start_hs = start_task_ready & start_task_valid & (start_task_slot == run_slot) & !fin_hs;
      run_hit = active & (abort_req_slot == run_slot);
      disp_hit = task_rvalid & (task_rslot == abort_req_slot);
      abort_run = abort_req_valid & ((run_hit & !fin_hs) | disp_hit);
      drop_en = abort_req_valid & !run_hit & !disp_hit;
      abort_running_task = abort_flag & active;
      abort_running_slot = run_slot;
   end
   // live bits: set on push, cleared on pop or when a buffered task is aborted
   always_comb begin
      live_nxt = live_q;
      drop_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         drop_mask[i] = drop_en & live_q[i] & (slot_q[i] == abort_req_slot);
         live_nxt[i] = (live_q[i] & !drop_mask[i] & !(pop & (rd_idx == AW'(i)))) | (push & (wr_idx == AW'(i)));
      end
   end
   // ready buffer storage, pointers and the dropped-task pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         live_q <= '0;
         dropped_valid <= 1'b0;
         dropped_slot <= '0;
      end else begin
         if (push) begin
            task_q[wr_idx] <= rdy_task;
            slot_q[wr_idx] <= rdy_slot;
         end
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
         live_q <= live_nxt;
         dropped_valid <= |drop_mask;
         if (|drop_mask) dropped_slot <= abort_req_slot;
      end
   end
   // in-flight task FSM with registered started/finished outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         run_slot <= '0;
         abort_flag <= 1'b0;
         started_valid <= 1'b0;
         started_slot <= '0;
         finished_valid <= 1'b0;
         finished_slot <= '0;
         finished_children <= '0;
         finished_undo <= 1'b0;
         finished_aborted <= 1'b0;
         num_dispatched <= '0;
      end else begin
         started_valid <= start_hs;
         if (start_hs) started_slot <= run_slot;
         if (abort_run) abort_flag <= 1'b1;
         case (state)
            IDLE: if (task_rvalid) begin
               run_slot <= task_rslot;
               num_dispatched <= num_dispatched + 32'd1;
               state <= DISPATCHED;
            end
            DISPATCHED, RUNNING: if (fin_hs) begin
               finished_valid <= 1'b1;
               finished_slot <= finish_task_slot;
               finished_children <= finish_task_num_children;
               finished_undo <= finish_task_undo_log_write;
               finished_aborted <= abort_flag;
               state <= FINISHING;
            end else if (start_hs) state <= RUNNING;
            FINISHING: if (finished_ready) begin
               finished_valid <= 1'b0;
               abort_flag <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
   // a start for a slot other than the dispatched one is ignored and should never happen
   always_ff @(posedge clk) begin
      if (!rst && start_task_ready && start_task_valid)
         assert (start_task_slot == run_slot) else $error("core %0d: start slot mismatch", CORE_ID);
   end
endmodule

// File: tb/tb_cq_dispatch_port.sv
// tb_cq_dispatch_port: randomized scenario bench with a queue-based reference model
module tb_cq_dispatch_port;
   localparam int DEPTH = 4, TASK_W = 32, TTYPE_W = 4, SLOT_W = 8, CHILD_W = 3;
   typedef struct packed {logic [TASK_W-1:0] t; logic [SLOT_W-1:0] s;} ent_t;
   logic clk, rst, rdy_valid, rdy_ready, task_arvalid, task_rvalid;
   logic [TASK_W-1:0] rdy_task, task_rdata;
   logic [SLOT_W-1:0] rdy_slot, task_rslot, start_task_slot, finish_task_slot, abort_running_slot;
   logic [SLOT_W-1:0] abort_req_slot, started_slot, finished_slot, dropped_slot;
   logic [TTYPE_W-1:0] task_araddr;
   logic start_task_valid, start_task_ready, finish_task_valid, finish_task_undo_log_write, finish_task_ready;
   logic [CHILD_W-1:0] finish_task_num_children, finished_children;
   logic abort_running_task, abort_req_valid, started_valid, finished_valid, finished_ready;
   logic finished_undo, finished_aborted, dropped_valid;
   logic [31:0] num_dispatched;
   int total = 0, passed = 0, n_disp = 0;
   ent_t mq[$];

   cq_dispatch_port #(.DEPTH(DEPTH), .CORE_ID(0), .TASK_W(TASK_W), .TTYPE_W(TTYPE_W), .SLOT_W(SLOT_W), .CHILD_W(CHILD_W)) dut (
      .clk(clk), .rst(rst), .rdy_valid(rdy_valid), .rdy_ready(rdy_ready), .rdy_task(rdy_task), .rdy_slot(rdy_slot),
      .task_arvalid(task_arvalid), .task_araddr(task_araddr), .task_rvalid(task_rvalid), .task_rdata(task_rdata),
      .task_rslot(task_rslot), .start_task_valid(start_task_valid), .start_task_slot(start_task_slot),
      .start_task_ready(start_task_ready), .finish_task_valid(finish_task_valid), .finish_task_slot(finish_task_slot),
      .finish_task_num_children(finish_task_num_children), .finish_task_undo_log_write(finish_task_undo_log_write),
      .finish_task_ready(finish_task_ready), .abort_running_task(abort_running_task),
      .abort_running_slot(abort_running_slot), .abort_req_valid(abort_req_valid), .abort_req_slot(abort_req_slot),
      .started_valid(started_valid), .started_slot(started_slot), .finished_valid(finished_valid),
      .finished_ready(finished_ready), .finished_slot(finished_slot), .finished_children(finished_children),
      .finished_undo(finished_undo), .finished_aborted(finished_aborted), .dropped_valid(dropped_valid),
      .dropped_slot(dropped_slot), .num_dispatched(num_dispatched)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [TASK_W-1:0] mk_task(input logic [TTYPE_W-1:0] tt);
      logic [TASK_W-1:0] v;
      v = TASK_W'($urandom());
      v[TTYPE_W-1:0] = tt;
      return v;
   endfunction

   function automatic logic [SLOT_W-1:0] fresh_slot();
      logic [SLOT_W-1:0] s;
      bit clash;
      do begin
         s = SLOT_W'($urandom_range(16, 255));
         clash = 0;
         foreach (mq[i]) if (mq[i].s == s) clash = 1;
      end while (clash);
      return s;
   endfunction

   task automatic push(input logic [TASK_W-1:0] t, input logic [SLOT_W-1:0] s);
      rdy_valid = 1; rdy_task = t; rdy_slot = s;
      tick();
      rdy_valid = 0;
      mq.push_back('{t: t, s: s});
   endtask

   task automatic complete(input logic [SLOT_W-1:0] s, input logic [CHILD_W-1:0] ch, input logic u, input logic st);
      if (st) begin
         start_task_valid = 1; start_task_slot = s;
         tick();
         start_task_valid = 0;
      end
      finish_task_valid = 1; finish_task_slot = s; finish_task_num_children = ch; finish_task_undo_log_write = u;
      tick();
      finish_task_valid = 0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1; task_arvalid = 1; task_araddr = 0;
      repeat (3) tick();
      total++; if (rdy_ready !== 1'b1 || task_rvalid !== 1'b0 || num_dispatched !== 32'd0)
         $display("FAIL reset_buf: rdy_ready=%0b rvalid=%0b ndisp=%0d want 1 0 0", rdy_ready, task_rvalid, num_dispatched); else passed++;
      total++; if (started_valid !== 1'b0 || finished_valid !== 1'b0 || dropped_valid !== 1'b0 || abort_running_task !== 1'b0)
         $display("FAIL reset_valids: st=%0b fin=%0b drop=%0b abort=%0b want 0 0 0 0", started_valid, finished_valid, dropped_valid, abort_running_task); else passed++;
      total++; if (started_slot !== 0 || finished_slot !== 0 || dropped_slot !== 0 || abort_running_slot !== 0 || finished_children !== 0 || finished_aborted !== 0 || finished_undo !== 0)
         $display("FAIL reset_slots: st=%0d fin=%0d drop=%0d abort=%0d ch=%0d want all 0", started_slot, finished_slot, dropped_slot, abort_running_slot, finished_children); else passed++;
      rst = 0; task_arvalid = 0;
      tick();
   endtask

   task automatic test_basic();
      logic [TASK_W-1:0] t;
      logic u;
      t = mk_task(0); u = 1'($urandom());
      push(t, 8'd5);
      task_arvalid = 1; task_araddr = 0; #1;
      total++; if (task_rvalid !== 1'b1 || task_rslot !== 8'd5 || task_rdata !== t)
         $display("FAIL basic_deq: rvalid=%0b slot=%0d data=%h want 1 5 %h", task_rvalid, task_rslot, task_rdata, t); else passed++;
      tick();
      task_arvalid = 0; void'(mq.pop_front()); n_disp++;
      total++; if (num_dispatched !== 32'(n_disp) || start_task_ready !== 1'b1)
         $display("FAIL basic_disp: ndisp=%0d start_ready=%0b want %0d 1", num_dispatched, start_task_ready, n_disp); else passed++;
      start_task_valid = 1; start_task_slot = 5;
      tick();
      start_task_valid = 0;
      total++; if (started_valid !== 1'b1 || started_slot !== 8'd5)
         $display("FAIL basic_start: valid=%0b slot=%0d want 1 5", started_valid, started_slot); else passed++;
      tick();
      total++; if (started_valid !== 1'b0)
         $display("FAIL basic_start_pulse: valid=%0b want 0", started_valid); else passed++;
      finish_task_valid = 1; finish_task_slot = 5; finish_task_num_children = 3; finish_task_undo_log_write = u; #1;
      total++; if (finish_task_ready !== 1'b1)
         $display("FAIL basic_fin_ready: got %0b want 1", finish_task_ready); else passed++;
      tick();
      finish_task_valid = 0;
      total++; if (finished_valid !== 1'b1 || finished_slot !== 8'd5 || finished_children !== 3'd3 || finished_aborted !== 1'b0 || finished_undo !== u)
         $display("FAIL basic_finish: v=%0b slot=%0d ch=%0d ab=%0b undo=%0b want 1 5 3 0 %0b", finished_valid, finished_slot, finished_children, finished_aborted, finished_undo, u); else passed++;
      tick();
      total++; if (finished_valid !== 1'b0)
         $display("FAIL basic_finish_release: valid=%0b want 0", finished_valid); else passed++;
   endtask

   task automatic test_type_mismatch();
      logic [SLOT_W-1:0] s;
      s = fresh_slot();
      push(mk_task(1), s);
      task_arvalid = 1; task_araddr = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         total++; if (task_rvalid !== 1'b0 || rdy_ready !== 1'b1)
            $display("FAIL mismatch_hold[%0d]: rvalid=%0b rdy_ready=%0b want 0 1", i, task_rvalid, rdy_ready); else passed++;
         tick();
      end
      total++; if (num_dispatched !== 32'(n_disp))
         $display("FAIL mismatch_ndisp: got %0d want %0d", num_dispatched, n_disp); else passed++;
      task_araddr = 1; #1;
      total++; if (task_rvalid !== 1'b1 || task_rslot !== s)
         $display("FAIL mismatch_retained: rvalid=%0b slot=%0d want 1 %0d", task_rvalid, task_rslot, s); else passed++;
      tick();
      task_arvalid = 0; void'(mq.pop_front()); n_disp++;
      complete(s, 0, 0, 1);
   endtask

   task automatic test_full_wrap();
      ent_t e;
      for (int r = 0; r < 2; r++) begin
         tick();
         for (int i = 0; i < DEPTH; i++) push(mk_task(TTYPE_W'($urandom_range(0, 15))), fresh_slot());
         total++; if (rdy_ready !== 1'b0)
            $display("FAIL full_ready[%0d]: got %0b want 0", r, rdy_ready); else passed++;
         rdy_valid = 1; rdy_task = mk_task(0); rdy_slot = fresh_slot();
         task_arvalid = 1; task_araddr = mq[0].t[TTYPE_W-1:0]; #1;
         total++; if (task_rvalid !== 1'b1 || task_rslot !== mq[0].s || rdy_ready !== 1'b0)
            $display("FAIL full_pop_same_cycle[%0d]: rvalid=%0b slot=%0d rdy_ready=%0b want 1 %0d 0", r, task_rvalid, task_rslot, rdy_ready, mq[0].s); else passed++;
         tick();
         rdy_valid = 0; task_arvalid = 0; e = mq.pop_front(); n_disp++;
         total++; if (rdy_ready !== 1'b1 || num_dispatched !== 32'(n_disp))
            $display("FAIL full_freed[%0d]: rdy_ready=%0b ndisp=%0d want 1 %0d", r, rdy_ready, num_dispatched, n_disp); else passed++;
         complete(e.s, 0, 0, 1);
         while (mq.size() > 0) begin
            e = mq.pop_front();
            task_arvalid = 1; task_araddr = e.t[TTYPE_W-1:0]; #1;
            total++; if (task_rvalid !== 1'b1 || task_rslot !== e.s || task_rdata !== e.t)
               $display("FAIL wrap_order[%0d]: rvalid=%0b slot=%0d data=%h want 1 %0d %h", r, task_rvalid, task_rslot, task_rdata, e.s, e.t); else passed++;
            tick();
            task_arvalid = 0; n_disp++;
            complete(e.s, 0, 0, 1);
         end
      end
   endtask

   task automatic test_abort_dispatched();
      logic [TASK_W-1:0] t;
      t = mk_task(TTYPE_W'($urandom_range(0, 15)));
      push(t, 8'd7);
      task_arvalid = 1; task_araddr = t[TTYPE_W-1:0];
      tick();
      task_arvalid = 0; void'(mq.pop_front()); n_disp++;
      abort_req_valid = 1; abort_req_slot = 7;
      tick();
      abort_req_valid = 0;
      total++; if (abort_running_task !== 1'b1 || abort_running_slot !== 8'd7 || dropped_valid !== 1'b0)
         $display("FAIL abort_disp: abort=%0b slot=%0d drop=%0b want 1 7 0", abort_running_task, abort_running_slot, dropped_valid); else passed++;
      finish_task_valid = 1; finish_task_slot = 7; finish_task_num_children = 1; finish_task_undo_log_write = 0; #1;
      total++; if (finish_task_ready !== 1'b1)
         $display("FAIL abort_disp_fin_ready: got %0b want 1", finish_task_ready); else passed++;
      tick();
      finish_task_valid = 0;
      total++; if (finished_valid !== 1'b1 || finished_aborted !== 1'b1 || finished_slot !== 8'd7 || abort_running_task !== 1'b0)
         $display("FAIL abort_disp_finish: v=%0b ab=%0b slot=%0d abort=%0b want 1 1 7 0", finished_valid, finished_aborted, finished_slot, abort_running_task); else passed++;
      tick();
   endtask

   task automatic test_abort_on_dispatch();
      logic [TASK_W-1:0] t;
      logic [SLOT_W-1:0] s;
      t = mk_task(TTYPE_W'($urandom_range(0, 15))); s = fresh_slot();
      push(t, s);
      task_arvalid = 1; task_araddr = t[TTYPE_W-1:0]; abort_req_valid = 1; abort_req_slot = s;
      tick();
      task_arvalid = 0; abort_req_valid = 0; void'(mq.pop_front()); n_disp++;
      total++; if (abort_running_task !== 1'b1 || abort_running_slot !== s || dropped_valid !== 1'b0)
         $display("FAIL abort_on_disp: abort=%0b slot=%0d drop=%0b want 1 %0d 0", abort_running_task, abort_running_slot, dropped_valid, s); else passed++;
      start_task_valid = 1; start_task_slot = s;
      tick();
      start_task_valid = 0;
      finish_task_valid = 1; finish_task_slot = s; finish_task_num_children = 0;
      tick();
      finish_task_valid = 0;
      total++; if (finished_valid !== 1'b1 || finished_aborted !== 1'b1)
         $display("FAIL abort_on_disp_finish: v=%0b ab=%0b want 1 1", finished_valid, finished_aborted); else passed++;
      tick();
   endtask

   task automatic test_abort_finish_same();
      logic [TASK_W-1:0] t;
      logic [SLOT_W-1:0] s;
      t = mk_task(TTYPE_W'($urandom_range(0, 15))); s = fresh_slot();
      push(t, s);
      task_arvalid = 1; task_araddr = t[TTYPE_W-1:0];
      tick();
      task_arvalid = 0; void'(mq.pop_front()); n_disp++;
      start_task_valid = 1; start_task_slot = s;
      tick();
      start_task_valid = 0;
      finish_task_valid = 1; finish_task_slot = s; finish_task_num_children = 2; abort_req_valid = 1; abort_req_slot = s;
      tick();
      finish_task_valid = 0; abort_req_valid = 0;
      total++; if (finished_valid !== 1'b1 || finished_aborted !== 1'b0 || finished_children !== 3'd2 || abort_running_task !== 1'b0)
         $display("FAIL abort_fin_same: v=%0b ab=%0b ch=%0d abort=%0b want 1 0 2 0", finished_valid, finished_aborted, finished_children, abort_running_task); else passed++;
      tick();
   endtask

   task automatic test_abort_buffered();
      ent_t e;
      int w;
      push(mk_task(TTYPE_W'($urandom_range(0, 15))), fresh_slot());
      push(mk_task(TTYPE_W'($urandom_range(0, 15))), fresh_slot());
      push(mk_task(TTYPE_W'($urandom_range(0, 15))), 8'd9);
      push(mk_task(TTYPE_W'($urandom_range(0, 15))), fresh_slot());
      abort_req_valid = 1; abort_req_slot = 9;
      tick();
      abort_req_valid = 0; mq.delete(2);
      total++; if (dropped_valid !== 1'b1 || dropped_slot !== 8'd9)
         $display("FAIL abort_buf_drop: v=%0b slot=%0d want 1 9", dropped_valid, dropped_slot); else passed++;
      tick();
      total++; if (dropped_valid !== 1'b0)
         $display("FAIL abort_buf_pulse: v=%0b want 0", dropped_valid); else passed++;
      while (mq.size() > 0) begin
         e = mq.pop_front();
         task_arvalid = 1; task_araddr = e.t[TTYPE_W-1:0]; w = 0; #1;
         while (task_rvalid !== 1'b1 && w < 6) begin tick(); w++; end
         total++; if (task_rvalid !== 1'b1 || task_rslot !== e.s)
            $display("FAIL abort_buf_order: rvalid=%0b slot=%0d want 1 %0d", task_rvalid, task_rslot, e.s); else passed++;
         tick();
         task_arvalid = 0; n_disp++;
         complete(e.s, 0, 0, 1);
      end
   endtask

   task automatic test_finish_hold();
      logic [TASK_W-1:0] t1, t2;
      logic [SLOT_W-1:0] s1, s2;
      logic [CHILD_W-1:0] ch;
      t1 = mk_task(TTYPE_W'($urandom_range(0, 15))); s1 = fresh_slot();
      push(t1, s1);
      t2 = mk_task(TTYPE_W'($urandom_range(0, 15))); s2 = fresh_slot();
      push(t2, s2);
      ch = CHILD_W'($urandom());
      task_arvalid = 1; task_araddr = t1[TTYPE_W-1:0];
      tick();
      task_arvalid = 0; void'(mq.pop_front()); n_disp++;
      start_task_valid = 1; start_task_slot = s1;
      tick();
      start_task_valid = 0; finished_ready = 0;
      finish_task_valid = 1; finish_task_slot = s1; finish_task_num_children = ch;
      tick();
      finish_task_valid = 0; task_arvalid = 1; task_araddr = t2[TTYPE_W-1:0];
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (finished_valid !== 1'b1 || finished_slot !== s1 || finished_children !== ch || finish_task_ready !== 1'b0 || task_rvalid !== 1'b0 || num_dispatched !== 32'(n_disp))
            $display("FAIL hold[%0d]: v=%0b slot=%0d ch=%0d fready=%0b rvalid=%0b ndisp=%0d want 1 %0d %0d 0 0 %0d", i, finished_valid, finished_slot, finished_children, finish_task_ready, task_rvalid, num_dispatched, s1, ch, n_disp); else passed++;
         tick();
      end
      finished_ready = 1;
      tick();
      total++; if (finished_valid !== 1'b0 || task_rvalid !== 1'b1 || task_rslot !== s2)
         $display("FAIL hold_release: v=%0b rvalid=%0b slot=%0d want 0 1 %0d", finished_valid, task_rvalid, task_rslot, s2); else passed++;
      tick();
      task_arvalid = 0; void'(mq.pop_front()); n_disp++;
      total++; if (num_dispatched !== 32'(n_disp))
         $display("FAIL hold_ndisp: got %0d want %0d", num_dispatched, n_disp); else passed++;
      complete(s2, 0, 0, 1);
   endtask

   task automatic test_random();
      ent_t e;
      int k, j, w;
      logic [SLOT_W-1:0] ds;
      logic [CHILD_W-1:0] ch;
      logic u, st, ab;
      for (int r = 0; r < 12; r++) begin
         tick();
         k = $urandom_range(1, DEPTH);
         for (int i = 0; i < k; i++) push(mk_task(TTYPE_W'($urandom_range(0, 15))), fresh_slot());
         if (k > 1 && $urandom_range(0, 1) == 1) begin
            j = $urandom_range(0, k - 1);
            ds = mq[j].s;
            abort_req_valid = 1; abort_req_slot = ds;
            tick();
            abort_req_valid = 0; mq.delete(j);
            total++; if (dropped_valid !== 1'b1 || dropped_slot !== ds)
               $display("FAIL rand_drop[%0d]: v=%0b slot=%0d want 1 %0d", r, dropped_valid, dropped_slot, ds); else passed++;
         end
         while (mq.size() > 0) begin
            e = mq.pop_front();
            ch = CHILD_W'($urandom()); u = 1'($urandom()); st = 1'($urandom()); ab = 1'($urandom());
            task_arvalid = 1; task_araddr = e.t[TTYPE_W-1:0]; w = 0; #1;
            while (task_rvalid !== 1'b1 && w < 6) begin tick(); w++; end
            total++; if (task_rvalid !== 1'b1 || task_rslot !== e.s || task_rdata !== e.t)
               $display("FAIL rand_deq[%0d]: rvalid=%0b slot=%0d data=%h want 1 %0d %h", r, task_rvalid, task_rslot, task_rdata, e.s, e.t); else passed++;
            tick();
            task_arvalid = 0; n_disp++;
            if (st) begin
               start_task_valid = 1; start_task_slot = e.s;
               tick();
               start_task_valid = 0;
               total++; if (started_valid !== 1'b1 || started_slot !== e.s)
                  $display("FAIL rand_start[%0d]: v=%0b slot=%0d want 1 %0d", r, started_valid, started_slot, e.s); else passed++;
            end
            if (ab) begin
               abort_req_valid = 1; abort_req_slot = e.s;
               tick();
               abort_req_valid = 0;
               total++; if (abort_running_task !== 1'b1 || abort_running_slot !== e.s)
                  $display("FAIL rand_abort[%0d]: abort=%0b slot=%0d want 1 %0d", r, abort_running_task, abort_running_slot, e.s); else passed++;
            end
            finish_task_valid = 1; finish_task_slot = e.s; finish_task_num_children = ch; finish_task_undo_log_write = u;
            tick();
            finish_task_valid = 0;
            total++; if (finished_valid !== 1'b1 || finished_slot !== e.s || finished_children !== ch || finished_undo !== u || finished_aborted !== ab || num_dispatched !== 32'(n_disp))
               $display("FAIL rand_finish[%0d]: v=%0b slot=%0d ch=%0d undo=%0b ab=%0b ndisp=%0d want 1 %0d %0d %0b %0b %0d", r, finished_valid, finished_slot, finished_children, finished_undo, finished_aborted, num_dispatched, e.s, ch, u, ab, n_disp); else passed++;
            tick();
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [TASK_W-1:0] t1, t2, t3;
      logic [SLOT_W-1:0] s1, s2, s3;
      tick();
      t1 = mk_task(TTYPE_W'($urandom_range(0, 15))); s1 = fresh_slot();
      push(t1, s1);
      t2 = mk_task(TTYPE_W'($urandom_range(0, 15))); s2 = fresh_slot();
      push(t2, s2);
      task_arvalid = 1; task_araddr = t1[TTYPE_W-1:0];
      tick();
      task_arvalid = 0;
      start_task_valid = 1; start_task_slot = s1;
      tick();
      start_task_valid = 0; rst = 1;
      tick();
      mq.delete(); n_disp = 0;
      total++; if (started_valid !== 1'b0 || abort_running_task !== 1'b0 || finished_valid !== 1'b0 || rdy_ready !== 1'b1 || num_dispatched !== 32'd0 || start_task_ready !== 1'b0 || finish_task_ready !== 1'b0)
         $display("FAIL reset_mid: st=%0b abort=%0b fin=%0b rdy=%0b ndisp=%0d sready=%0b fready=%0b want 0 0 0 1 0 0 0", started_valid, abort_running_task, finished_valid, rdy_ready, num_dispatched, start_task_ready, finish_task_ready); else passed++;
      rst = 0; task_arvalid = 1; task_araddr = t2[TTYPE_W-1:0];
      tick();
      total++; if (task_rvalid !== 1'b0)
         $display("FAIL reset_mid_empty: rvalid=%0b want 0", task_rvalid); else passed++;
      task_arvalid = 0;
      t3 = mk_task(TTYPE_W'($urandom_range(0, 15))); s3 = fresh_slot();
      push(t3, s3);
      task_arvalid = 1; task_araddr = t3[TTYPE_W-1:0]; #1;
      total++; if (task_rvalid !== 1'b1 || task_rslot !== s3)
         $display("FAIL reset_mid_after: rvalid=%0b slot=%0d want 1 %0d", task_rvalid, task_rslot, s3); else passed++;
      tick();
      task_arvalid = 0; void'(mq.pop_front()); n_disp++;
      total++; if (num_dispatched !== 32'(n_disp))
         $display("FAIL reset_mid_ndisp: got %0d want %0d", num_dispatched, n_disp); else passed++;
      complete(s3, 0, 0, 1);
   endtask

   initial begin
      rst = 1; rdy_valid = 0; rdy_task = '0; rdy_slot = '0; task_arvalid = 0; task_araddr = '0;
      start_task_valid = 0; start_task_slot = '0; finish_task_valid = 0; finish_task_slot = '0;
      finish_task_num_children = '0; finish_task_undo_log_write = 0; abort_req_valid = 0; abort_req_slot = '0;
      finished_ready = 1;
      test_reset();
      test_basic();
      test_type_mismatch();
      test_full_wrap();
      test_abort_dispatched();
      test_abort_on_dispatch();
      test_abort_finish_same();
      test_abort_buffered();
      test_finish_hold();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/cq_dispatch_port.md
# cq_dispatch_port

Per-core responder for the task dequeue, start, finish and abort protocol driven by each core's task-execution FSM. Sits in the commit-queue slice between the CQ's dispatch logic and one core. It buffers up to four dispatchable tasks, answers the core's dequeue requests by task type, and tracks the single in-flight task through start and finish. It also routes CQ abort requests either to the running task or to a buffered one.

## Interface
- `DEPTH`, 4: ready-buffer entries (power of two, ≥2)
- `CORE_ID`, 0: core index (stats only)
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `rdy_valid` in 1, `rdy_ready` out 1, `rdy_task` in task_t, `rdy_slot` in cq_slice_slot_t: tasks from the CQ
- `task_arvalid` in 1, `task_araddr` in task_type_t: core dequeue request
- `task_rvalid` out 1, `task_rdata` out task_t, `task_rslot` out cq_slice_slot_t: dequeue response
- `start_task_valid` in 1, `start_task_slot` in cq_slice_slot_t, `start_task_ready` out 1
- `finish_task_valid` in 1, `finish_task_slot` in cq_slice_slot_t, `finish_task_num_children` in child_id_t, `finish_task_undo_log_write` in 1, `finish_task_ready` out 1
- `abort_running_task` out 1, `abort_running_slot` out cq_slice_slot_t: to core
- `abort_req_valid` in 1, `abort_req_slot` in cq_slice_slot_t: from CQ, single-cycle pulse
- `started_valid` out 1, `started_slot` out cq_slice_slot_t: to CQ
- `finished_valid` out 1, `finished_ready` in 1, `finished_slot` out cq_slice_slot_t, `finished_children` out child_id_t, `finished_undo` out 1, `finished_aborted` out 1
- `dropped_valid` out 1, `dropped_slot` out cq_slice_slot_t: buffered task killed by abort
- `num_dispatched` out 32: dispatch count

## Operation
- Ready buffer: circular FIFO of {task, slot, live}. Pointers and count are `$clog2(DEPTH)+1` bits and wrap naturally.
  - `rdy_ready = (count < DEPTH)`. A pop in the same cycle does not free space.
- Dispatch FSM states: IDLE, DISPATCHED, RUNNING, FINISHING.
  - IDLE: `task_rvalid = task_arvalid & head.live & head.ttype==task_araddr & count>0`. On handshake: pop, latch `run_slot`, go to DISPATCHED, increment `num_dispatched`.
  - A head with live=0 is popped silently in IDLE. While such a head is present, `task_rvalid` = 0.
  - DISPATCHED: `start_task_ready = 1`. On `start_task_valid` with a matching slot, pulse `started_valid`/`started_slot` for one cycle and go to RUNNING. On a slot mismatch, stay and keep ready (the event is ignored; checked by assertion).
  - DISPATCHED, abort-pending variant: the core skips start and goes straight to finish, so a finish handshake is also accepted here.
  - RUNNING (and DISPATCHED): `finish_task_ready = !finished_valid`. On a finish handshake with a matching slot, register the finish outputs, set `finished_aborted = abort_flag`, and go to FINISHING.
  - FINISHING: hold the `finished_*` outputs until `finished_ready`, then go to IDLE and clear `abort_flag`.
- Abort routing on `abort_req_valid`:
  - If the slot equals `run_slot` and the state is DISPATCHED or RUNNING, set `abort_flag`. `abort_running_task = abort_flag` (a level, held until FINISHING is entered). `abort_running_slot = run_slot`.
  - Otherwise, if it matches a live buffer entry, clear that entry's live bit and pulse `dropped_valid`/`dropped_slot` next cycle.
  - Otherwise the request is ignored.

## Timing
- Reset values:
  - state=IDLE, count/pointers=0, all live bits=0
  - `rdy_ready`=1
  - all valids, `abort_running_task`, `finished_*`, `dropped_valid` = 0
  - slot outputs = 0
  - `num_dispatched` = 0
- `task_rvalid`, `task_rdata` and `task_rslot` are combinational from the FIFO head and `task_arvalid` (zero-latency, same-cycle handshake). `task_rdata` is valid only when `task_rvalid` is high.
- A task pushed at cycle N is dispatchable at N+1.
- `started_valid` and `dropped_valid` are registered: they appear one cycle after their triggering event.
- `finished_valid` rises the cycle after the core's finish handshake.
- Simultaneous events:
  - Abort and finish handshake in the same cycle: finish wins, `finished_aborted` = 0, abort ignored.
  - Abort and dispatch of the same slot in the same cycle: the abort applies to the running task (`abort_flag` set on entering DISPATCHED).
  - Push and pop in the same cycle: count unchanged.
- Reset asserted mid-task discards all state with no output pulses.

## Test plan
- Push slot 5, ttype 0; core requests ttype 0 → `task_rvalid` the same cycle with `task_rslot`=5; start → `started_valid` pulse with slot 5; finish with 3 children → `finished_children`=3, `finished_aborted`=0.
- Head ttype 1, core requests ttype 0 → `task_rvalid` stays 0 and `count` unchanged for 10 cycles.
- Fill 4 entries → `rdy_ready`=0; dispatch one → `rdy_ready`=1 the next cycle; pointer wraps after 8 pushes with FIFO order preserved.
- Abort slot 7 while DISPATCHED on slot 7 → `abort_running_task`=1 and `abort_running_slot`=7; the core finishes without starting → `finished_aborted`=1 and the abort signal drops.
- Abort slot 9 buffered at position 2 → `dropped_valid` with slot 9; the next dequeues return the remaining slots in order and skip 9.
- Hold `finished_ready`=0 for 5 cycles → `finished_*` stable, `finish_task_ready`=0, no new dispatch until release.
